// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter (request-to-send, frame shift-out on device clocks, ACK check).
// Optional macro PS2_TX_RETRY_EN: on NACK or timeout, retry once with the same byte before reporting.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_req_i,
  input  logic [7:0] tx_data_i,
  output logic       busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o,
  input  logic       clk_pin_i,
  input  logic       data_pin_i,
  output logic       clk_drive_low_o,
  output logic       data_drive_low_o
);

  localparam int unsigned MaxCycles =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxCycles + 1);
  localparam logic [TimerW-1:0] InhLast = TimerW'(INHIBIT_CYCLES - 1);
  localparam logic [TimerW-1:0] ToLast  = TimerW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StInhibit  = 4'd1;
  localparam logic [3:0] StStart    = 4'd2;
  localparam logic [3:0] StData     = 4'd3;
  localparam logic [3:0] StParity   = 4'd4;
  localparam logic [3:0] StStop     = 4'd5;
  localparam logic [3:0] StWaitAck  = 4'd6;
  localparam logic [3:0] StWaitIdle = 4'd7;
  localparam logic [3:0] StDone     = 4'd8;

  logic [3:0]        state_q, state_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              data_low_q, data_low_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
`ifdef PS2_TX_RETRY_EN
  logic [7:0]        byte_q, byte_d;
  logic              retry_q, retry_d;
`endif

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic fall;
  logic timed;
  logic fail;

  // Pins idle high, so the synchronizers reset to 1 to avoid a spurious fall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_pin_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= data_pin_i;
      data_sync_q <= data_meta_q;
    end
  end

  assign fall  = clk_prev_q & ~clk_sync_q;
  assign timed = (state_q >= StStart) && (state_q <= StWaitIdle);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    cnt_d      = cnt_q;
    data_low_d = data_low_q;
    ack_d      = ack_q;
    err_d      = err_q;
    timer_d    = timer_q + TimerW'(1);
    fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
    byte_d     = byte_q;
    retry_d    = retry_q;
`endif

    case (state_q)
      StIdle: begin
        if (tx_req_i) begin
          shift_d = tx_data_i;
          par_d   = ~^tx_data_i;
          cnt_d   = 4'd0;
          ack_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StInhibit;
`ifdef PS2_TX_RETRY_EN
          byte_d  = tx_data_i;
          retry_d = 1'b0;
`endif
        end
      end
      StInhibit: begin
        if (timer_q == InhLast) begin
          data_low_d = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (fall) begin
          data_low_d = ~shift_q[0];
          shift_d    = shift_q >> 1;
          cnt_d      = cnt_q + 4'd1;
          state_d    = StData;
        end
      end
      StData: begin
        if (fall) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd8) begin
            data_low_d = ~par_q;
            state_d    = StParity;
          end else begin
            data_low_d = ~shift_q[0];
            shift_d    = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (fall) begin
          data_low_d = 1'b0;
          cnt_d      = cnt_q + 4'd1;
          state_d    = StStop;
        end
      end
      StStop: begin
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (fall) begin
          ack_d   = ~data_sync_q;
          cnt_d   = cnt_q + 4'd1;
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (clk_sync_q && data_sync_q) begin
          if (ack_q) begin
            state_d = StDone;
          end else begin
            fail = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A timeout only fires when nothing else moved the FSM this cycle.
    if (timed && !fall && (state_d == state_q) && (timer_q == ToLast)) begin
      fail = 1'b1;
    end

    if (fail) begin
      data_low_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        shift_d = byte_q;
        cnt_d   = 4'd0;
        ack_d   = 1'b0;
        state_d = StInhibit;
      end else begin
        err_d   = 1'b1;
        state_d = StDone;
      end
`else
      err_d   = 1'b1;
      state_d = StDone;
`endif
    end

    if ((state_d != state_q) || (timed && fall) || (state_q == StIdle)) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      cnt_q      <= 4'd0;
      timer_q    <= '0;
      data_low_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      data_low_q <= data_low_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

`ifdef PS2_TX_RETRY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_q  <= 8'h00;
      retry_q <= 1'b0;
    end else begin
      byte_q  <= byte_d;
      retry_q <= retry_d;
    end
  end
`endif

  assign busy_o          = (state_q != StIdle);
  assign tx_done_o       = (state_q == StDone);
  assign tx_err_o        = err_q;
  assign clk_drive_low_o = (state_q == StInhibit);
  // Start bit goes out on the final inhibit cycle, ahead of the clock release.
  assign data_drive_low_o = data_low_q | ((state_q == StInhibit) && (timer_q == InhLast));

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: table vectors, random bytes vs. a frame model, and corner sequences.
module tb_ps2_tx;
  localparam int unsigned InhCyc = 10;
  localparam int unsigned ToCyc  = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy, tx_done, tx_err, cdl, ddl;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_pin, data_pin;

  // Open-drain wired-AND of host and device pulls.
  assign clk_pin  = ~(cdl | dev_clk_low);
  assign data_pin = ~(ddl | dev_data_low);

  always #5 clk = ~clk;

  ps2_tx #(
    .INHIBIT_CYCLES(InhCyc),
    .TIMEOUT_CYCLES(ToCyc)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .tx_req_i        (tx_req),
    .tx_data_i       (tx_data),
    .busy_o          (busy),
    .tx_done_o       (tx_done),
    .tx_err_o        (tx_err),
    .clk_pin_i       (clk_pin),
    .data_pin_i      (data_pin),
    .clk_drive_low_o (cdl),
    .data_drive_low_o(ddl)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int inh_start_cyc = 0;
  int inh_run = 0;
  int inh_len = 0;
  logic last_err = 1'b0;
  logic prev_cdl = 1'b0;
  logic prev_ddl = 1'b0;
  logic ddl_at_inh_end = 1'b0;
  logic [10:0] bits;

  always @(negedge clk) begin
    cyc++;
    if (tx_done) begin
      done_cnt++;
      last_err = tx_err;
      last_done_cyc = cyc;
    end
    if (cdl) begin
      if (!prev_cdl) begin
        inh_start_cyc = cyc;
        inh_run = 0;
      end
      inh_run++;
    end else if (prev_cdl) begin
      inh_len = inh_run;
      ddl_at_inh_end = prev_ddl;
    end
    prev_cdl = cdl;
    prev_ddl = ddl;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic wait_done(input int start_cnt, input string name);
    int t = 0;
    while (done_cnt == start_cnt && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == start_cnt) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no tx_done within 3000 cycles", name);
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req  = 1'b0;
  endtask

  // Device: waits for RTS, samples each bit just before pulling clk low, 40-cycle period.
  task automatic device_frame(input bit ack_low, input int abort_k, output logic [10:0] fb);
    int t = 0;
    fb = '0;
    while (cdl !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    while ((cdl !== 1'b0 || data_pin !== 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_fail++;
      $display("FAIL dev_start: no request-to-send seen within 3000 cycles");
      return;
    end
    for (int k = 0; k < 11; k++) begin
      repeat (20) @(negedge clk);
      fb[k] = data_pin;
      dev_clk_low = 1'b1;
      if (k == 10 && ack_low) dev_data_low = 1'b1;
      if (k == abort_k) begin
        repeat (10) @(negedge clk);
        check("abort_pre_ddl", ddl, 1'b1);
        check("abort_pre_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_cdl", cdl, 1'b0);
        check("abort_ddl", ddl, 1'b0);
        check("abort_done", tx_done, 1'b0);
        dev_clk_low = 1'b0;
        return;
      end
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (20) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic run_tx(input logic [7:0] b, input bit ack_low, input string name,
                        output logic [10:0] fb);
    int dc = done_cnt;
    logic exp_err;
`ifdef PS2_TX_RETRY_EN
    exp_err = 1'b0;
`else
    exp_err = ~ack_low;
`endif
    start_tx(b);
    device_frame(ack_low, -1, fb);
`ifdef PS2_TX_RETRY_EN
    if (!ack_low) device_frame(1'b1, -1, fb);
`endif
    wait_done(dc, name);
    check({name, "_frame"}, 32'(fb), 32'(frame_of(b)));
    check({name, "_err"}, last_err, exp_err);
    check({name, "_ndone"}, done_cnt - dc, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         ack_low;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int dc;
    int d1;
    int attempts;
    logic [7:0] rb;
    bit rack;

    vecs[0] = '{data: 8'hED, par: 1'b1, ack_low: 1'b1};
    vecs[1] = '{data: 8'h07, par: 1'b0, ack_low: 1'b1};
    vecs[2] = '{data: 8'h00, par: 1'b1, ack_low: 1'b1};
    vecs[3] = '{data: 8'hFF, par: 1'b1, ack_low: 1'b1};
    vecs[4] = '{data: 8'hAA, par: 1'b1, ack_low: 1'b0};
    vecs[5] = '{data: 8'h01, par: 1'b0, ack_low: 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", tx_done, 1'b0);
    check("rst_err", tx_err, 1'b0);
    check("rst_cdl", cdl, 1'b0);
    check("rst_ddl", ddl, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED with good ACK: exact frame and inhibit length.
    run_tx(8'hED, 1'b1, "ed", bits);
    check("ed_const_frame", 32'(bits), 32'(11'b1_1_11101101_0));
    check("ed_inh_len", inh_len, InhCyc);
    check("ed_start_on_last_inh", ddl_at_inh_end, 1'b1);

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      run_tx(vecs[i].data, vecs[i].ack_low, $sformatf("vec%0d", i), bits);
      check($sformatf("vec%0d_par", i), bits[9], vecs[i].par);
      repeat (5) @(negedge clk);
    end

    // Back-to-back with tx_req held: one idle cycle between done and next inhibit.
    dc = done_cnt;
    @(negedge clk);
    tx_data = 8'h07;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_data = 8'h00;
    device_frame(1'b1, -1, bits);
    check("b2b0_par", bits[9], 1'b0);
    check("b2b0_frame", 32'(bits), 32'(frame_of(8'h07)));
    wait_done(dc, "b2b0");
    d1 = last_done_cyc;
    repeat (3) @(negedge clk);
    tx_req = 1'b0;
    device_frame(1'b1, -1, bits);
    check("b2b1_par", bits[9], 1'b1);
    check("b2b1_frame", 32'(bits), 32'(frame_of(8'h00)));
    wait_done(dc + 1, "b2b1");
    check("b2b_gap", inh_start_cyc - d1, 2);
    check("b2b1_err", last_err, 1'b0);
    repeat (5) @(negedge clk);

    // Device never clocks: timeout 200 cycles after START entry.
    start_tx(8'hED);
`ifdef PS2_TX_RETRY_EN
    attempts = 2;
`else
    attempts = 1;
`endif
    for (int a = 0; a < attempts; a++) begin
      int t = 0;
      while (!cdl && t < 100) begin
        @(negedge clk);
        t++;
      end
      while (cdl && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("to_start_seen", (t < 100), 1'b1);
      repeat (ToCyc - 1) @(negedge clk);
      check("to_pre_ddl", ddl, 1'b1);
      check("to_pre_done", tx_done, 1'b0);
      @(negedge clk);
      if (a == attempts - 1) begin
        check("to_done", tx_done, 1'b1);
        check("to_err", tx_err, 1'b1);
        check("to_cdl", cdl, 1'b0);
        check("to_ddl", ddl, 1'b0);
      end else begin
        check("to_retry_cdl", cdl, 1'b1);
        check("to_retry_done", tx_done, 1'b0);
      end
    end
    repeat (5) @(negedge clk);

    // Reset during DATA at bit 4, then a normal 0xFF.
    dc = done_cnt;
    start_tx(8'hED);
    device_frame(1'b1, 4, bits);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - dc, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_tx(8'hFF, 1'b1, "post_rst", bits);
    repeat (5) @(negedge clk);

    // tx_req with 0xAA while busy is ignored.
    dc = done_cnt;
    start_tx(8'hED);
    fork
      device_frame(1'b1, -1, bits);
      begin
        repeat (100) @(negedge clk);
        tx_data = 8'hAA;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_req  = 1'b0;
      end
    join
    wait_done(dc, "busy_req");
    check("busy_req_frame", 32'(bits), 32'(frame_of(8'hED)));
    check("busy_req_err", last_err, 1'b0);
    repeat (30) @(negedge clk);
    check("busy_req_idle", busy, 1'b0);
    check("busy_req_ndone", done_cnt - dc, 1);

    // Randomized bytes and ACK behaviour against the frame model.
    for (int i = 0; i < 8; i++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      run_tx(rb, rack, $sformatf("rnd%0d", i), bits);
      repeat (3) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte (LED set 0xED, reset 0xFF, and similar) from the host to the keyboard over the same open-drain clk/data lines that the host receiver listens on.
- It runs the request-to-send sequence, shifts out the frame on device-generated clocks, and checks the device ACK bit.
- It sits beside the PS/2 receiver. The top level must hold the receiver in reset while busy=1.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles the PS/2 clock is held low before the start bit (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clk cycles between consecutive device clock falling edges, and in WAIT_IDLE (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous reset, active-low. Asserts immediately; deassertion must be synchronous to clk at top level.
- tx_req  in  1  transmit request. Sampled only in IDLE.
- tx_data  in  8  byte to send. Latched in the cycle tx_req is accepted.
- busy  out  1  high from the cycle after acceptance until the cycle tx_done pulses, inclusive.
- tx_done  out  1  one-cycle pulse when the transfer ends, whether it succeeds or fails.
- tx_err  out  1  valid while tx_done=1. Held until the next accepted request. 1 = missing ACK or timeout.
- clk_pin  in  1  PS/2 clock line as read back.
- data_pin  in  1  PS/2 data line as read back.
- clk_drive_low  out  1  1 = pull the PS/2 clock low; 0 = release it (open-drain).
- data_drive_low  out  1  1 = pull the PS/2 data line low; 0 = release it.

Behaviour:
- Reset, with rst=0:
  - busy, tx_done, tx_err, clk_drive_low and data_drive_low are all 0.
  - State goes to IDLE; shift register, bit counter and timer are cleared.
  - Reset mid-transfer releases both lines immediately, with no completion pulse.
- Input conditioning:
  - clk_pin and data_pin each pass through a 2-FF synchronizer.
  - A device clock falling edge (fall) is synchronized clk_pin going 1 then 0 on consecutive cycles. It is detected 3 cycles after the pin edge.
- Frame: start bit 0, data bits d0..d7 (LSB first), odd parity bit (~^tx_data), stop bit 1 (line released), then the device ACK bit, which must be 0.
- States:
  - IDLE: if tx_req=1, latch tx_data, compute parity, clear bit counter, go to INHIBIT. busy=1 from the next cycle.
  - INHIBIT: clk_drive_low=1 for exactly INHIBIT_CYCLES cycles. On the last of these cycles data_drive_low=1. Then go to START.
  - START: clk_drive_low=0, data_drive_low stays 1 (start bit). Wait for fall.
  - DATA: on falls 1..8, data_drive_low = ~d[n-1]. The bit counter increments on each fall.
  - PARITY: on fall 9, data_drive_low = ~parity.
  - STOP: on fall 10, data_drive_low=0 (line released).
  - WAIT_ACK: on fall 11, sample synchronized data_pin. ACK = (data_pin==0). Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synchronized clk_pin=1 and data_pin=1 on the same cycle. Then go to DONE.
  - DONE: tx_done=1 for one cycle, tx_err = ~ACK, busy drops the next cycle, return to IDLE.
- Timeout:
  - The timer restarts on every fall and on every state entry.
  - It runs in START, DATA, PARITY, STOP, WAIT_ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: release both lines, set tx_err=1, go to DONE.
- Busy handling:
  - tx_req while busy=1 is ignored and is not queued.
  - tx_req held high across DONE is accepted again in the following IDLE cycle, so there is one idle cycle between transfers.
- Counter width: $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1) bits. The bit counter is 4 bits.

Optional Feature:
- Macro PS2_TX_RETRY_EN.
- When defined:
  - On a NACK or timeout, the block re-enters INHIBIT once with the same latched byte, and busy stays high.
  - tx_done pulses only after the retry attempt. tx_err reflects that second attempt.
  - Adds a 1-bit retry flag, cleared on acceptance.
- When undefined: the first failure completes immediately with tx_err=1.

Test Plan:
- Send 0xED with INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200, and a device model clocking a 40-cycle period that drives ACK=0:
  - clk_drive_low is high for exactly 10 cycles.
  - The device samples 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Result: tx_done pulse with tx_err=0.
- Send 0x07 (parity 0) and 0x00 (parity 1) back-to-back with tx_req held high:
  - The parity bits sample as 0 and 1.
  - There is exactly one idle cycle between the first tx_done and the second INHIBIT.
- Device leaves data high on the ACK clock:
  - Without the macro: tx_err=1 at tx_done.
  - With PS2_TX_RETRY_EN: a second INHIBIT follows, and a good ACK on retry gives tx_err=0.
- Device never clocks after the INHIBIT phase:
  - 200 cycles after START entry, both drive outputs are 0 and tx_done is pulsed with tx_err=1.
- Assert rst=0 during DATA at bit 4:
  - Same cycle: both drive outputs are 0, busy=0, and there is no tx_done.
  - A subsequent 0xFF request completes normally.
- Pulse tx_req with 0xAA while busy:
  - It is ignored.
  - The in-flight byte 0xED is transmitted unchanged.
